pk_extractor: RTL and testbench

Downstream consumer of the GF(2^M) systemizer. After the systemizer reports done without fail, the top-level controller pulses `start`. This block then reads the systemized L x K matrix through the systemizer's read port and drops the identity part, the left L columns. It realigns the remaining K-L columns of every row to N-element word boundaries and streams them out as public-key words over a valid/ready handshake.

---
 rtl/pk_extractor_if.sv | 24 ++
 rtl/pk_extractor.sv | 195 +++++++++++++++++++
 tb/tb_pk_extractor.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pk_extractor_if.sv
// Read port toward the systemizer plus the public-key output stream.
// master = pk_extractor side, slave = memory / consumer side.
interface pk_extractor_if #(
    parameter int N  = 20,
    parameter int M  = 1,
    parameter int AW = 12
);
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [N*M-1:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [N*M-1:0] out_data;

    modport master (
        output rd_en, rd_addr, out_valid, out_data,
        input  rd_data, out_ready
    );

    modport slave (
        input  rd_en, rd_addr, out_valid, out_data,
        output rd_data, out_ready
    );
endinterface

// File: rtl/pk_extractor.sv
// Strips the identity columns from the systemized matrix and streams the rest as words.
// Optional identity check enabled by defining PKX_IDENTITY_CHECK_EN.
module pk_extractor #(
    parameter int N = 20,
    parameter int M = 1,
    parameter int L = 200,
    parameter int K = 400
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    output logic id_fail,
    pk_extractor_if.master bus
);
    localparam int W  = K / N;
    localparam int C0 = L / N;
    localparam int S  = L % N;
    localparam int DW = N * M;
    localparam int AW = $clog2(L * K / N);
    localparam int RW = $clog2(L + 1);
    localparam int CW = $clog2(W + 1);
`ifdef PKX_IDENTITY_CHECK_EN
    localparam int CS = 0;
`else
    localparam int CS = C0;
`endif

    if (K % N != 0) begin : g_chk
        $error("pk_extractor: K must be a multiple of N");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nx;

    logic [RW-1:0] r;
    logic [CW-1:0] c;
    logic [CW-1:0] dc;
    logic [AW-1:0] rd_addr;
    logic          rd_en, dv;
    logic          go, issue, last_rd, can_rd, drained;
    logic          pop, push, hv, hf;
    logic [DW-1:0] pdata, rd_data;
    logic [DW-1:0] fmem [4];
    logic [1:0]    wp, rp;
    logic [2:0]    occ;
    logic [3:0]    pend;

    assign rd_data       = bus.rd_data;
    assign bus.rd_en     = rd_en;
    assign bus.rd_addr   = rd_addr;
    assign bus.out_valid = occ != 3'd0;
    assign bus.out_data  = fmem[rp];
    assign busy          = state != IDLE;

    assign pop     = bus.out_valid && bus.out_ready;
    assign last_rd = (r == RW'(L - 1)) && (c == CW'(W - 1));
    // every read or held word will become exactly one FIFO entry at most
    assign pend    = 4'(occ) + 4'(rd_en) + 4'(dv) + 4'(hv) - 4'(pop);
    assign can_rd  = pend < 4'd4;
    assign drained = !rd_en && !dv && !hv && !hf && (occ == 3'd0);

    always_comb begin
        state_nx = state;
        go       = 1'b0;
        issue    = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    go       = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (last_rd) state_nx = DRAIN;
                else if (can_rd) issue = 1'b1;
            end
            DRAIN: begin
                if (drained) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            r       <= '0;
            c       <= '0;
            rd_addr <= '0;
            rd_en   <= 1'b0;
            dv      <= 1'b0;
            dc      <= '0;
        end else begin
            state <= state_nx;
            rd_en <= go | issue;
            dv    <= rd_en;
            dc    <= c;
            if (go) begin
                r       <= '0;
                c       <= CW'(CS);
                rd_addr <= AW'(CS);
            end else if (issue) begin
                if (c == CW'(W - 1)) begin
                    c       <= CW'(CS);
                    r       <= r + RW'(1);
                    rd_addr <= rd_addr + AW'(W - C0 + CS - (W - C0) + 1);
                end else begin
                    c       <= c + CW'(1);
                    rd_addr <= rd_addr + AW'(1);
                end
            end
        end
    end

    if (S > 0) begin : g_realign
        logic [DW-1:0] hold;
        logic is_data, first, lastc;
        assign is_data = dv && (dc >= CW'(C0));
        assign first   = dc == CW'(C0);
        assign lastc   = dc == CW'(W - 1);
        // hf flushes the row tail (zero-padded) while the next row's first word lands in hold
        assign push    = hf || (is_data && !first);
        assign pdata   = hf ? {{(S * M){1'b0}}, hold[DW-1:S*M]}
                            : {rd_data[S*M-1:0], hold[DW-1:S*M]};
        always_ff @(posedge clk) begin
            if (rst) begin
                hold <= '0;
                hv   <= 1'b0;
                hf   <= 1'b0;
            end else begin
                hf <= is_data && lastc;
                if (is_data) begin
                    hold <= rd_data;
                    hv   <= 1'b1;
                end else if (hf) begin
                    hv <= 1'b0;
                end
            end
        end
    end else begin : g_direct
        assign push  = dv && (dc >= CW'(C0));
        assign pdata = rd_data;
        assign hv    = 1'b0;
        assign hf    = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) fmem[i] <= '0;
            wp  <= '0;
            rp  <= '0;
            occ <= '0;
        end else begin
            if (push) begin
                fmem[wp] <= pdata;
                wp       <= wp + 2'd1;
            end
            if (pop) rp <= rp + 2'd1;
            occ <= occ + 3'(push) - 3'(pop);
        end
    end

`ifdef PKX_IDENTITY_CHECK_EN
    logic [RW-1:0] dr;
    logic          bad;

    always_comb begin
        bad = 1'b0;
        for (int e = 0; e < N; e++) begin
            if (dv && (int'(dc) * N + e < L)
                && (rd_data[e*M +: M] != ((int'(dc) * N + e == int'(dr)) ? M'(1) : M'(0))))
                bad = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dr      <= '0;
            id_fail <= 1'b0;
        end else begin
            dr <= r;
            if (go) id_fail <= 1'b0;
            else if (bad) id_fail <= 1'b1;
        end
    end
`else
    assign id_fail = 1'b0;
`endif
endmodule

// File: tb/tb_pk_extractor.sv
// Bench for pk_extractor: small S>0 instance (N=4,L=6,K=12) and default S=0 instance.
// Expected words come from a column-level model of the matrix with identity dropped.
module tb_pk_extractor;
    localparam int SN = 4, SM = 1, SL = 6, SK = 12;
    localparam int SW = SK / SN, SWR = SW - SL / SN;
    localparam int SAW = $clog2(SL * SK / SN);
    localparam int BN = 20, BM = 1, BL = 200, BK = 400;
    localparam int BW = BK / BN, BWR = BW - BL / BN;
    localparam int BAW = $clog2(BL * BK / BN);
`ifdef PKX_IDENTITY_CHECK_EN
    localparam bit IDCHK = 1'b1;
`else
    localparam bit IDCHK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic s_start, s_busy, s_done, s_idf;
    logic b_start, b_busy, b_done, b_idf;

    pk_extractor_if #(.N(SN), .M(SM), .AW(SAW)) sif ();
    pk_extractor_if #(.N(BN), .M(BM), .AW(BAW)) bif ();

    pk_extractor #(.N(SN), .M(SM), .L(SL), .K(SK)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .busy(s_busy),
        .done(s_done), .id_fail(s_idf), .bus(sif.master)
    );

    pk_extractor #(.N(BN), .M(BM), .L(BL), .K(BK)) u_big (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy),
        .done(b_done), .id_fail(b_idf), .bus(bif.master)
    );

    logic [SN-1:0] smem [SL * SW];
    logic [BN-1:0] bmem [BL * BW];

    always @(posedge clk) if (sif.rd_en) sif.rd_data <= smem[sif.rd_addr];
    always @(posedge clk) if (bif.rd_en) bif.rd_data <= bmem[bif.rd_addr];

    int checks = 0;
    int failures = 0;
    bit exp_idf = 1'b0;
    logic [SN-1:0] got[$];

    // element j of row r of the K-column matrix, public part starts at column L
    function automatic logic [SN-1:0] exp_s(int r, int w);
        logic [SN-1:0] v;
        v = '0;
        for (int e = 0; e < SN; e++) begin
            int j;
            j = SL + w * SN + e;
            if (j < SK) v[e] = smem[r * SW + j / SN][j % SN];
        end
        return v;
    endfunction

    function automatic logic [BN-1:0] exp_b(int r, int w);
        logic [BN-1:0] v;
        v = '0;
        for (int e = 0; e < BN; e++) begin
            int j;
            j = BL + w * BN + e;
            if (j < BK) v[e] = bmem[r * BW + j / BN][j % BN];
        end
        return v;
    endfunction

    task automatic test_reset;
        logic [31:0] obs [8];
        string nm [8];
        rst = 1'b1;
        s_start = 1'b0;
        b_start = 1'b0;
        sif.out_ready = 1'b1;
        bif.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        obs = '{32'(s_busy), 32'(s_done), 32'(sif.rd_en), 32'(sif.rd_addr),
                32'(sif.out_valid), 32'(sif.out_data), 32'(s_idf), 32'(bif.out_valid)};
        nm = '{"busy", "done", "rd_en", "rd_addr", "out_valid", "out_data", "id_fail", "big_valid"};
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs[i] !== 32'd0) begin
                failures++;
                $display("FAIL reset_%s got=%0h exp=0", nm[i], obs[i]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_small(input int mode, input bit chain);
        int last_hs, dones, first_v, lim;
        logic [SN-1:0] prev_d;
        bit prev_stall;
        last_hs = -10;
        dones = 0;
        first_v = -1;
        prev_stall = 1'b0;
        prev_d = '0;
        lim = IDCHK ? 5 : 4;
        got.delete();
        sif.out_ready = 1'b1;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        checks++;
        if (s_busy !== 1'b1 || sif.rd_en !== 1'b1) begin
            failures++;
            $display("FAIL start_resp busy=%b rd_en=%b exp=1,1", s_busy, sif.rd_en);
        end
        for (int cyc = 1; cyc < 400; cyc++) begin
            sif.out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall) begin
                checks++;
                if (sif.out_valid !== 1'b1 || sif.out_data !== prev_d) begin
                    failures++;
                    $display("FAIL stall_hold cyc=%0d valid=%b data=%h exp=1,%h",
                             cyc, sif.out_valid, sif.out_data, prev_d);
                end
            end
            if (sif.out_valid === 1'b1 && first_v < 0) first_v = cyc;
            if (s_done === 1'b1) begin
                dones++;
                checks++;
                if (cyc != last_hs + 1) begin
                    failures++;
                    $display("FAIL done_timing cyc=%0d exp=%0d", cyc, last_hs + 1);
                end
            end
            s_start = (mode == 2) && (s_busy === 1'b1) && ((cyc % 3 == 0) || (s_done === 1'b1));
            if (sif.out_valid === 1'b1 && sif.out_ready === 1'b1) begin
                got.push_back(sif.out_data);
                last_hs = cyc;
            end
            prev_stall = (sif.out_valid === 1'b1) && (sif.out_ready !== 1'b1);
            prev_d = sif.out_data;
            if (dones > 0 && (chain || cyc > last_hs + 3)) break;
            @(negedge clk);
        end
        s_start = 1'b0;
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL done_count got=%0d exp=1", dones);
        end
        checks++;
        if (got.size() != SL * SWR) begin
            failures++;
            $display("FAIL word_count got=%0d exp=%0d", got.size(), SL * SWR);
        end
        for (int i = 0; i < got.size() && i < SL * SWR; i++) begin
            checks++;
            if (got[i] !== exp_s(i / SWR, i % SWR)) begin
                failures++;
                $display("FAIL word_%0d got=%h exp=%h", i, got[i], exp_s(i / SWR, i % SWR));
            end
        end
        checks++;
        if (first_v < 1 || first_v > lim) begin
            failures++;
            $display("FAIL first_valid got=%0d exp<=%0d", first_v, lim);
        end
        checks++;
        if (s_idf !== exp_idf) begin
            failures++;
            $display("FAIL id_fail got=%b exp=%b", s_idf, exp_idf);
        end
        if (mode == 2) begin
            checks++;
            if (s_busy !== 1'b0) begin
                failures++;
                $display("FAIL start_at_done busy=%b exp=0", s_busy);
            end
        end
        if (chain) @(negedge clk);
    endtask

    task automatic test_stream_small;
        run_small(0, 1'b0);
    endtask

    task automatic test_random_ready;
        for (int k = 0; k < 3; k++) run_small(1, 1'b0);
    endtask

    task automatic test_start_while_busy;
        run_small(2, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_small(0, 1'b1);
        run_small(0, 1'b0);
    endtask

    task automatic test_reset_midrun;
        int n;
        logic [31:0] obs [7];
        n = 0;
        sif.out_ready = 1'b1;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (sif.out_valid === 1'b1 && n == 5) break;
            if (sif.out_valid === 1'b1) n++;
            @(negedge clk);
        end
        checks++;
        if (n != 5) begin
            failures++;
            $display("FAIL reach_word5 got=%0d exp=5", n);
        end
        rst = 1'b1;
        @(negedge clk);
        obs = '{32'(s_busy), 32'(s_done), 32'(sif.rd_en), 32'(sif.rd_addr),
                32'(sif.out_valid), 32'(sif.out_data), 32'(s_idf)};
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (obs[i] !== 32'd0) begin
                failures++;
                $display("FAIL midrst_out%0d got=%0h exp=0", i, obs[i]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        run_small(0, 1'b0);
    endtask

    task automatic test_identity;
        smem[3 * SW + 0][3] = 1'b0;
        exp_idf = IDCHK;
        run_small(0, 1'b0);
        smem[3 * SW + 0][3] = 1'b1;
        exp_idf = 1'b0;
        repeat (2) @(negedge clk);
        run_small(0, 1'b0);
    endtask

    task automatic test_s0_stream;
        int idx, dones, first_v, bubbles, last_hs, lim;
        idx = 0;
        dones = 0;
        first_v = -1;
        bubbles = 0;
        last_hs = -10;
        lim = IDCHK ? 3 + BL / BN : 3;
        bif.out_ready = 1'b1;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int cyc = 1; cyc < 8000; cyc++) begin
            if (bif.out_valid === 1'b1) begin
                if (first_v < 0) first_v = cyc;
            end else if (first_v >= 0 && idx < BL * BWR) begin
                bubbles++;
            end
            if (b_done === 1'b1) begin
                dones++;
                checks++;
                if (cyc != last_hs + 1) begin
                    failures++;
                    $display("FAIL big_done_timing cyc=%0d exp=%0d", cyc, last_hs + 1);
                end
            end
            if (bif.out_valid === 1'b1 && bif.out_ready === 1'b1) begin
                checks++;
                if (bif.out_data !== exp_b(idx / BWR, idx % BWR)) begin
                    failures++;
                    $display("FAIL big_word_%0d got=%h exp=%h", idx, bif.out_data,
                             exp_b(idx / BWR, idx % BWR));
                end
                idx++;
                last_hs = cyc;
            end
            if (dones > 0 && cyc > last_hs + 3) break;
            @(negedge clk);
        end
        checks++;
        if (idx != BL * BWR) begin
            failures++;
            $display("FAIL big_word_count got=%0d exp=%0d", idx, BL * BWR);
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL big_done_count got=%0d exp=1", dones);
        end
        checks++;
        if (first_v < 1 || first_v > lim) begin
            failures++;
            $display("FAIL big_first_valid got=%0d exp<=%0d", first_v, lim);
        end
`ifndef PKX_IDENTITY_CHECK_EN
        checks++;
        if (bubbles != 0) begin
            failures++;
            $display("FAIL big_bubbles got=%0d exp=0", bubbles);
        end
`endif
        checks++;
        if (b_idf !== 1'b0) begin
            failures++;
            $display("FAIL big_id_fail got=%b exp=0", b_idf);
        end
    endtask

    initial begin
        rst = 1'b1;
        s_start = 1'b0;
        b_start = 1'b0;
        sif.out_ready = 1'b1;
        bif.out_ready = 1'b1;
        for (int a = 0; a < SL * SW; a++) smem[a] = SN'($urandom);
        for (int r = 0; r < SL; r++)
            for (int j = 0; j < SL; j++)
                smem[r * SW + j / SN][j % SN] = (j == r);
        for (int a = 0; a < BL * BW; a++) bmem[a] = BN'($urandom);
        for (int r = 0; r < BL; r++)
            for (int cw = 0; cw < BL / BN; cw++)
                bmem[r * BW + cw] = (r / BN == cw) ? (BN'(1) << (r % BN)) : '0;

        test_reset();
        test_stream_small();
        test_random_ready();
        test_start_while_busy();
        test_back_to_back();
        test_reset_midrun();
        test_identity();
        test_s0_stream();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
